// File: rtl/uart_xcvr_cfg.sv
// Configurable UART transceiver: 16x-oversampled TX/RX with per-frame config latching,
// TX/RX FIFOs (RX first-word fall-through) and internal loopback.
module uart_xcvr_cfg #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CLK_FQ     = 25000000,
    parameter int unsigned BR         = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cfg_div,
    input  logic [1:0]  cfg_dbits,
    input  logic [1:0]  cfg_par,
    input  logic        cfg_stop2,
    input  logic        cfg_loopback,
    input  logic        wr_uart,
    input  logic [7:0]  w_data,
    output logic        tx_fifo_full,
    output logic        tx_fifo_empty,
    output logic        tx_busy,
    output logic        tx,
    input  logic        rx,
    input  logic        rd_uart,
    output logic [7:0]  r_data,
    output logic [1:0]  r_err,
    output logic        rx_fifo_empty,
    output logic        rx_fifo_full,
    output logic        rx_overrun
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_DEF = 16'(CLK_FQ / (16 * BR) - 1);

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxPar, TxStop} tx_state_t;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxPar, RxStop} rx_state_t;

    logic [15:0] w_div;
    assign w_div = (cfg_div == 16'd0) ? DIV_DEF : cfg_div;

    // ---------------- TX FIFO ----------------
    logic [7:0]    r_txf_mem [FIFO_DEPTH];
    logic [AW-1:0] r_txf_wptr, r_txf_rptr;
    logic [AW:0]   r_txf_cnt;
    logic          r_txf_full, r_txf_empty;
    logic          w_txf_push, w_txf_pop;
    logic [AW:0]   w_txf_cnt_nxt;

    assign w_txf_push    = wr_uart && (!r_txf_full || w_txf_pop);
    assign w_txf_cnt_nxt = r_txf_cnt + {{AW{1'b0}}, w_txf_push} - {{AW{1'b0}}, w_txf_pop};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_txf_wptr  <= '0;
            r_txf_rptr  <= '0;
            r_txf_cnt   <= '0;
            r_txf_full  <= 1'b0;
            r_txf_empty <= 1'b1;
        end else begin
            if (w_txf_push) r_txf_wptr <= r_txf_wptr + AW'(1);
            if (w_txf_pop)  r_txf_rptr <= r_txf_rptr + AW'(1);
            r_txf_cnt   <= w_txf_cnt_nxt;
            r_txf_full  <= (w_txf_cnt_nxt == (AW + 1)'(FIFO_DEPTH));
            r_txf_empty <= (w_txf_cnt_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_txf_push) r_txf_mem[r_txf_wptr] <= w_data;
    end

    // ---------------- TX FSM ----------------
    tx_state_t   r_tx_state, w_tx_state_nxt;
    logic [15:0] r_tx_div, r_tx_div_cnt;
    logic [4:0]  r_tx_tick;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_data;
    logic [1:0]  r_tx_dbits, r_tx_par;
    logic        r_tx_stop2;
    logic        w_tx_tick, w_tx_bit_done, w_tx_stop_done, w_tx_last, w_tx_par_en;
    logic        w_tx_load, w_tx_line;
    logic [7:0]  w_tx_mask;

    assign w_tx_mask      = 8'hFF >> (~cfg_dbits);
    assign w_tx_tick      = (r_tx_div_cnt == r_tx_div);
    assign w_tx_bit_done  = w_tx_tick && (r_tx_tick[3:0] == 4'd15);
    assign w_tx_stop_done = w_tx_tick && (r_tx_tick == (r_tx_stop2 ? 5'd31 : 5'd15));
    assign w_tx_last      = (r_tx_bit == {1'b1, r_tx_dbits});
    assign w_tx_par_en    = (r_tx_par == 2'b01) || (r_tx_par == 2'b10);

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_txf_pop      = 1'b0;
        w_tx_load      = 1'b0;
        w_tx_line      = 1'b1;
        unique case (r_tx_state)
            TxIdle: begin
                if (!r_txf_empty) begin
                    w_txf_pop      = 1'b1;
                    w_tx_load      = 1'b1;
                    w_tx_state_nxt = TxStart;
                end
            end
            TxStart: begin
                w_tx_line = 1'b0;
                if (w_tx_bit_done) w_tx_state_nxt = TxData;
            end
            TxData: begin
                w_tx_line = r_tx_data[r_tx_bit];
                if (w_tx_bit_done && w_tx_last) w_tx_state_nxt = w_tx_par_en ? TxPar : TxStop;
            end
            TxPar: begin
                w_tx_line = (^r_tx_data) ^ r_tx_par[1];
                if (w_tx_bit_done) w_tx_state_nxt = TxStop;
            end
            TxStop: begin
                // Chain straight into the next frame so queued words leave with no gap
                if (w_tx_stop_done) begin
                    if (!r_txf_empty) begin
                        w_txf_pop      = 1'b1;
                        w_tx_load      = 1'b1;
                        w_tx_state_nxt = TxStart;
                    end else begin
                        w_tx_state_nxt = TxIdle;
                    end
                end
            end
            default: w_tx_state_nxt = TxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state   <= TxIdle;
            r_tx_div     <= '0;
            r_tx_div_cnt <= '0;
            r_tx_tick    <= '0;
            r_tx_bit     <= '0;
            r_tx_data    <= '0;
            r_tx_dbits   <= '0;
            r_tx_par     <= '0;
            r_tx_stop2   <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            if (w_tx_load) begin
                r_tx_data    <= r_txf_mem[r_txf_rptr] & w_tx_mask;
                r_tx_div     <= w_div;
                r_tx_dbits   <= cfg_dbits;
                r_tx_par     <= cfg_par;
                r_tx_stop2   <= cfg_stop2;
                r_tx_div_cnt <= '0;
                r_tx_tick    <= '0;
                r_tx_bit     <= '0;
            end else if (r_tx_state != TxIdle) begin
                if (w_tx_tick) begin
                    r_tx_div_cnt <= '0;
                    if (r_tx_state == TxData && w_tx_bit_done) begin
                        r_tx_tick <= '0;
                        r_tx_bit  <= r_tx_bit + 3'd1;
                    end else if (w_tx_state_nxt != r_tx_state) begin
                        r_tx_tick <= '0;
                    end else begin
                        r_tx_tick <= r_tx_tick + 5'd1;
                    end
                end else begin
                    r_tx_div_cnt <= r_tx_div_cnt + 16'd1;
                end
            end
        end
    end

    assign tx_busy       = (r_tx_state != TxIdle);
    assign tx            = cfg_loopback ? 1'b1 : w_tx_line;
    assign tx_fifo_full  = r_txf_full;
    assign tx_fifo_empty = r_txf_empty;

    // ---------------- RX front end ----------------
    logic r_rx_s1, r_rx_s2, r_rx_s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= cfg_loopback ? w_tx_line : rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t   r_rx_state, w_rx_state_nxt;
    logic [15:0] r_rx_div, r_rx_div_cnt;
    logic [3:0]  r_rx_tick;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_data;
    logic [1:0]  r_rx_dbits, r_rx_par;
    logic        r_rx_perr, r_rx_ovr;
    logic        w_rx_tick, w_rx_mid, w_rx_begin, w_rx_push_req;

    assign w_rx_tick = (r_rx_div_cnt == r_rx_div);
    assign w_rx_mid  = w_rx_tick && (r_rx_tick == 4'd15);

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_begin     = 1'b0;
        w_rx_push_req  = 1'b0;
        unique case (r_rx_state)
            RxIdle: begin
                if (r_rx_s3 && !r_rx_s2) begin
                    w_rx_begin     = 1'b1;
                    w_rx_state_nxt = RxStart;
                end
            end
            RxStart: begin
                if (w_rx_tick && r_rx_tick == 4'd7) w_rx_state_nxt = r_rx_s2 ? RxIdle : RxData;
            end
            RxData: begin
                if (w_rx_mid && r_rx_bit == {1'b1, r_rx_dbits})
                    w_rx_state_nxt = (r_rx_par == 2'b01 || r_rx_par == 2'b10) ? RxPar : RxStop;
            end
            RxPar: begin
                if (w_rx_mid) w_rx_state_nxt = RxStop;
            end
            RxStop: begin
                if (w_rx_mid) begin
                    w_rx_push_req  = 1'b1;
                    w_rx_state_nxt = RxIdle;
                end
            end
            default: w_rx_state_nxt = RxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state   <= RxIdle;
            r_rx_div     <= '0;
            r_rx_div_cnt <= '0;
            r_rx_tick    <= '0;
            r_rx_bit     <= '0;
            r_rx_data    <= '0;
            r_rx_dbits   <= '0;
            r_rx_par     <= '0;
            r_rx_perr    <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            if (w_rx_begin) begin
                r_rx_div     <= w_div;
                r_rx_dbits   <= cfg_dbits;
                r_rx_par     <= cfg_par;
                r_rx_div_cnt <= '0;
                r_rx_tick    <= '0;
                r_rx_bit     <= '0;
                r_rx_data    <= '0;
                r_rx_perr    <= 1'b0;
            end else if (r_rx_state != RxIdle) begin
                if (w_rx_tick) begin
                    r_rx_div_cnt <= '0;
                    // Half-bit realignment after the start check; 4-bit wrap gives 16 ticks/bit
                    r_rx_tick <= (r_rx_state == RxStart && r_rx_tick == 4'd7) ? 4'd0
                                                                               : r_rx_tick + 4'd1;
                    if (r_rx_state == RxData && w_rx_mid) begin
                        r_rx_data[r_rx_bit] <= r_rx_s2;
                        r_rx_bit            <= r_rx_bit + 3'd1;
                    end
                    if (r_rx_state == RxPar && w_rx_mid)
                        r_rx_perr <= (r_rx_s2 != ((^r_rx_data) ^ r_rx_par[1]));
                end else begin
                    r_rx_div_cnt <= r_rx_div_cnt + 16'd1;
                end
            end
        end
    end

    // ---------------- RX FIFO ----------------
    logic [9:0]    r_rxf_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rxf_wptr, r_rxf_rptr;
    logic [AW:0]   r_rxf_cnt;
    logic          r_rxf_full, r_rxf_empty;
    logic          w_rxf_push, w_rxf_pop;
    logic [AW:0]   w_rxf_cnt_nxt;
    logic [9:0]    w_rxf_head;

    assign w_rxf_pop     = rd_uart && !r_rxf_empty;
    assign w_rxf_push    = w_rx_push_req && (!r_rxf_full || w_rxf_pop);
    assign w_rxf_cnt_nxt = r_rxf_cnt + {{AW{1'b0}}, w_rxf_push} - {{AW{1'b0}}, w_rxf_pop};
    assign w_rxf_head    = r_rxf_mem[r_rxf_rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxf_wptr  <= '0;
            r_rxf_rptr  <= '0;
            r_rxf_cnt   <= '0;
            r_rxf_full  <= 1'b0;
            r_rxf_empty <= 1'b1;
            r_rx_ovr    <= 1'b0;
        end else begin
            if (w_rxf_push) r_rxf_wptr <= r_rxf_wptr + AW'(1);
            if (w_rxf_pop)  r_rxf_rptr <= r_rxf_rptr + AW'(1);
            r_rxf_cnt   <= w_rxf_cnt_nxt;
            r_rxf_full  <= (w_rxf_cnt_nxt == (AW + 1)'(FIFO_DEPTH));
            r_rxf_empty <= (w_rxf_cnt_nxt == '0);
            r_rx_ovr    <= w_rx_push_req && r_rxf_full && !rd_uart;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rxf_push) r_rxf_mem[r_rxf_wptr] <= {r_rx_perr, ~r_rx_s2, r_rx_data};
    end

    assign r_data        = r_rxf_empty ? 8'h00 : w_rxf_head[7:0];
    assign r_err         = r_rxf_empty ? 2'b00 : w_rxf_head[9:8];
    assign rx_fifo_empty = r_rxf_empty;
    assign rx_fifo_full  = r_rxf_full;
    assign rx_overrun    = r_rx_ovr;

endmodule

// File: tb/tb_uart_xcvr_cfg.sv
// Directed self-checking bench for uart_xcvr_cfg (DUT built with FIFO_DEPTH=4).
module tb_uart_xcvr_cfg;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_dbits, cfg_par;
    logic        cfg_stop2, cfg_loopback;
    logic        wr_uart, rd_uart, rx;
    logic [7:0]  w_data;
    logic        tx_fifo_full, tx_fifo_empty, tx_busy, tx;
    logic [7:0]  r_data;
    logic [1:0]  r_err;
    logic        rx_fifo_empty, rx_fifo_full, rx_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_xcvr_cfg #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .cfg_div(cfg_div), .cfg_dbits(cfg_dbits),
        .cfg_par(cfg_par), .cfg_stop2(cfg_stop2), .cfg_loopback(cfg_loopback),
        .wr_uart(wr_uart), .w_data(w_data), .tx_fifo_full(tx_fifo_full),
        .tx_fifo_empty(tx_fifo_empty), .tx_busy(tx_busy), .tx(tx), .rx(rx),
        .rd_uart(rd_uart), .r_data(r_data), .r_err(r_err), .rx_fifo_empty(rx_fifo_empty),
        .rx_fifo_full(rx_fifo_full), .rx_overrun(rx_overrun)
    );

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; wr_uart = 1'b0; rd_uart = 1'b0; rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Drives n serial bits LSB first, 32 clocks each (cfg_div=1), then idles the line high
    task automatic send_frame(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            repeat (32) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic test_reset();
        cfg_loopback = 1'b0;
        apply_reset();
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b exp 1", tx); end
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", tx_busy); end
        n_checks++; if (tx_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_txe got %b exp 1", tx_fifo_empty); end
        n_checks++; if (tx_fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_txf got %b exp 0", tx_fifo_full); end
        n_checks++; if (rx_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_rxe got %b exp 1", rx_fifo_empty); end
        n_checks++; if (rx_fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_rxf got %b exp 0", rx_fifo_full); end
        n_checks++; if (r_data !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h exp 00", r_data); end
        n_checks++; if (r_err !== 2'b00) begin n_fail++; $display("FAIL reset_rerr got %b exp 00", r_err); end
        n_checks++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got %b exp 0", rx_overrun); end
    endtask

    task automatic test_loopback_default();
        int busy_cnt = 0, tx_low = 0, fall_at = -1;
        apply_reset();
        cfg_div = 16'd0; cfg_dbits = 2'b11; cfg_par = 2'b00; cfg_stop2 = 1'b0;
        cfg_loopback = 1'b1;
        wr_uart = 1'b1; w_data = 8'hA5;
        @(negedge clk);
        wr_uart = 1'b0;
        for (int c = 0; c < 2600; c++) begin
            @(negedge clk);
            if (tx_busy) busy_cnt++;
            if (tx !== 1'b1) tx_low++;
            if (!rx_fifo_empty && fall_at < 0) fall_at = c;
        end
        n_checks++; if (busy_cnt != 2080) begin n_fail++; $display("FAIL lb_busy_len got %0d exp 2080", busy_cnt); end
        n_checks++; if (tx_low != 0) begin n_fail++; $display("FAIL lb_tx_held got %0d low cycles exp 0", tx_low); end
        n_checks++;
        if (fall_at < 1970 || fall_at > 1990) begin
            n_fail++; $display("FAIL lb_rx_latency got %0d exp 1970..1990", fall_at);
        end
        n_checks++; if (r_data !== 8'hA5) begin n_fail++; $display("FAIL lb_rdata got %h exp a5", r_data); end
        n_checks++; if (r_err !== 2'b00) begin n_fail++; $display("FAIL lb_rerr got %b exp 00", r_err); end
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
        n_checks++; if (rx_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL lb_pop_empty got %b exp 1", rx_fifo_empty); end
        n_checks++; if (r_data !== 8'h00) begin n_fail++; $display("FAIL lb_pop_rdata got %h exp 00", r_data); end
    endtask

    task automatic test_tx_framing();
        logic [10:0] exp_bits = 11'b111_1010_1010;
        int busy_cnt = 0;
        int found = 0;
        apply_reset();
        cfg_div = 16'd3; cfg_dbits = 2'b10; cfg_par = 2'b10; cfg_stop2 = 1'b1;
        cfg_loopback = 1'b0;
        wr_uart = 1'b1; w_data = 8'h55;
        @(negedge clk);
        wr_uart = 1'b0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1;
        end
        n_checks++;
        if (found == 0) begin
            n_fail++; $display("FAIL txf_start got no start bit exp tx=0 within 20 clks");
            return;
        end
        for (int c = 0; c < 800; c++) begin
            if (tx_busy) busy_cnt++;
            if (c < 704 && (c % 64) == 32) begin
                n_checks++;
                if (tx !== exp_bits[c / 64]) begin
                    n_fail++; $display("FAIL txf_bit%0d got %b exp %b", c / 64, tx, exp_bits[c / 64]);
                end
            end
            if (c == 63 || c == 64) begin
                n_checks++;
                if (tx !== (c == 64)) begin
                    n_fail++; $display("FAIL txf_edge_c%0d got %b exp %b", c, tx, (c == 64));
                end
            end
            @(negedge clk);
        end
        n_checks++; if (busy_cnt != 704) begin n_fail++; $display("FAIL txf_busy_len got %0d exp 704", busy_cnt); end
    endtask

    task automatic test_rx_errors();
        apply_reset();
        cfg_div = 16'd1; cfg_dbits = 2'b11; cfg_par = 2'b01; cfg_stop2 = 1'b0;
        cfg_loopback = 1'b0;
        send_frame(12'h678, 11);
        repeat (40) @(negedge clk);
        n_checks++; if (r_data !== 8'h3C) begin n_fail++; $display("FAIL rxe_par_data got %h exp 3c", r_data); end
        n_checks++; if (r_err !== 2'b10) begin n_fail++; $display("FAIL rxe_par_err got %b exp 10", r_err); end
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
        send_frame(12'h102, 11);
        repeat (40) @(negedge clk);
        n_checks++; if (r_data !== 8'h81) begin n_fail++; $display("FAIL rxe_frm_data got %h exp 81", r_data); end
        n_checks++; if (r_err !== 2'b01) begin n_fail++; $display("FAIL rxe_frm_err got %b exp 01", r_err); end
    endtask

    task automatic test_glitch();
        apply_reset();
        cfg_div = 16'd1; cfg_dbits = 2'b11; cfg_par = 2'b00; cfg_stop2 = 1'b0;
        cfg_loopback = 1'b0;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        n_checks++; if (rx_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL glitch_empty got %b exp 1", rx_fifo_empty); end
        send_frame(12'h2B4, 10);
        repeat (40) @(negedge clk);
        n_checks++; if (r_data !== 8'h5A) begin n_fail++; $display("FAIL glitch_next_data got %h exp 5a", r_data); end
        n_checks++; if (r_err !== 2'b00) begin n_fail++; $display("FAIL glitch_next_err got %b exp 00", r_err); end
    endtask

    task automatic test_back_to_back_overrun();
        logic [7:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        int busy_cnt = 0, segs = 0, ovr_cnt = 0;
        logic prev_busy = 1'b0;
        logic full_at_ovr = 1'b0;
        apply_reset();
        cfg_div = 16'd1; cfg_dbits = 2'b11; cfg_par = 2'b00; cfg_stop2 = 1'b0;
        cfg_loopback = 1'b1;
        for (int c = 0; c < 2400; c++) begin
            if (tx_busy) busy_cnt++;
            if (tx_busy && !prev_busy) segs++;
            prev_busy = tx_busy;
            if (rx_overrun) begin
                if (ovr_cnt == 0) full_at_ovr = rx_fifo_full;
                ovr_cnt++;
            end
            if (c == 5) begin
                n_checks++;
                if (tx_fifo_full !== 1'b1) begin n_fail++; $display("FAIL b2b_txf_full got %b exp 1", tx_fifo_full); end
            end
            if (c < 5) begin
                wr_uart = 1'b1; w_data = words[c];
            end else begin
                wr_uart = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++; if (busy_cnt != 1600) begin n_fail++; $display("FAIL b2b_busy_len got %0d exp 1600", busy_cnt); end
        n_checks++; if (segs != 1) begin n_fail++; $display("FAIL b2b_busy_gaps got %0d runs exp 1", segs); end
        n_checks++; if (ovr_cnt != 1) begin n_fail++; $display("FAIL ovr_pulses got %0d exp 1", ovr_cnt); end
        n_checks++; if (full_at_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_full_before got %b exp 1", full_at_ovr); end
        n_checks++; if (rx_fifo_full !== 1'b1) begin n_fail++; $display("FAIL ovr_rxf got %b exp 1", rx_fifo_full); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (r_data !== words[i]) begin n_fail++; $display("FAIL ovr_pop%0d got %h exp %h", i, r_data, words[i]); end
            rd_uart = 1'b1;
            @(negedge clk);
        end
        rd_uart = 1'b0;
        n_checks++; if (rx_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL ovr_drained got %b exp 1", rx_fifo_empty); end
    endtask

    task automatic test_reset_mid_frame();
        int busy_cnt = 0, rx_pushes = 0;
        apply_reset();
        cfg_div = 16'd1; cfg_dbits = 2'b11; cfg_par = 2'b00; cfg_stop2 = 1'b0;
        cfg_loopback = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_uart = 1'b1; w_data = 8'hC0 + 8'(i);
            @(negedge clk);
        end
        wr_uart = 1'b0;
        repeat (128) @(negedge clk);
        n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_busy got %b exp 1", tx_busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx got %b exp 1", tx); end
        n_checks++; if (tx_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid_txe got %b exp 1", tx_fifo_empty); end
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b exp 0", tx_busy); end
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (tx_busy) busy_cnt++;
            if (!rx_fifo_empty) rx_pushes++;
        end
        n_checks++; if (busy_cnt != 0) begin n_fail++; $display("FAIL rst_mid_after_busy got %0d exp 0", busy_cnt); end
        n_checks++; if (rx_pushes != 0) begin n_fail++; $display("FAIL rst_mid_rx_push got %0d exp 0", rx_pushes); end
    endtask

    initial begin
        reset = 1'b1; wr_uart = 1'b0; rd_uart = 1'b0; rx = 1'b1; w_data = 8'h00;
        cfg_div = 16'd0; cfg_dbits = 2'b11; cfg_par = 2'b00; cfg_stop2 = 1'b0;
        cfg_loopback = 1'b0;
        test_reset();
        test_loopback_default();
        test_tx_framing();
        test_rx_errors();
        test_glitch();
        test_back_to_back_overrun();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_xcvr_cfg.md
UART_XCVR_CFG -- requirements
Module: uart_xcvr_cfg

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, entries per TX and per RX FIFO (power of 2, ≥2).
REQ-002 SHALL have parameter CLK_FQ, default 25000000, clock frequency in Hz.
REQ-003 SHALL have parameter BR, default 115200, default baud rate.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port cfg_div, input, 16, 16x-oversample tick divisor; 0 selects DIV_DEF = CLK_FQ/(16*BR)-1 (integer, 12 at defaults).
REQ-007 SHALL have port cfg_dbits, input, 2, data bits: 00=5, 01=6, 10=7, 11=8.
REQ-008 SHALL have port cfg_par, input, 2, parity: 00=none, 01=even, 10=odd, 11=none.
REQ-009 SHALL have port cfg_stop2, input, 1, 1 = two stop bits transmitted.
REQ-010 SHALL have port cfg_loopback, input, 1, 1 = internal tx-to-rx loopback.
REQ-011 SHALL have ports wr_uart (input, 1, TX FIFO push) and w_data (input, 8, push data, LSBs used).
REQ-012 SHALL have outputs tx_fifo_full (1), tx_fifo_empty (1), tx_busy (1, frame in progress) and tx (1, serial out).
REQ-013 SHALL have ports rx (input, 1, serial in) and rd_uart (input, 1, RX FIFO pop).
REQ-014 SHALL have outputs r_data (8), r_err (2, {parity_err, framing_err}), rx_fifo_empty (1), rx_fifo_full (1) and rx_overrun (1, one-cycle pulse).

Function
REQ-015 SHALL generate one tick every (div+1) clocks, div = cfg_div or DIV_DEF; bit time = 16 ticks.
REQ-016 SHALL sample all cfg_* inputs at frame start (TX: leaving IDLE; RX: start-bit detect) and hold them for that frame.
REQ-017 TX FSM SHALL be IDLE -> START -> DATA -> PARITY (only if parity enabled) -> STOP -> IDLE; each bit lasts 16 ticks, STOP lasts 16 or 32 ticks.
REQ-018 In IDLE with TX FIFO non-empty, TX SHALL pop the head word and drive tx=0 on the following clock; data goes out LSB first.
REQ-019 Parity bit SHALL be XOR of the transmitted data bits (even) or its inverse (odd); tx=1 in IDLE and STOP.
REQ-020 tx_busy SHALL be 1 from the START state entry through the last STOP cycle; back-to-back frames SHALL have no idle gap.
REQ-021 RX FSM SHALL be IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE; input passes a 2-flop synchroniser.
REQ-022 RX START SHALL re-sample 8 ticks after the falling edge; rx=1 at that point returns to IDLE with no push (glitch reject).
REQ-023 RX SHALL sample each subsequent bit at its mid-point (every 16 ticks); data right-aligned, unused upper bits 0.
REQ-024 parity_err SHALL be set on parity mismatch; framing_err SHALL be set when the first stop sample is 0; RX checks only one stop bit.
REQ-025 At STOP mid-sample RX SHALL push {err, data} into the RX FIFO; if full, the word is dropped, rx_overrun pulses for 1 cycle, and FIFO contents stay unchanged.
REQ-026 RX FIFO SHALL be first-word fall-through: r_data/r_err show head when not empty, 0 when empty; rd_uart pops.
REQ-027 Push when full (no pop that cycle) and pop when empty SHALL be ignored with no state change.
REQ-028 Simultaneous push and pop SHALL both occur, including when full (count unchanged); when empty, the pop is ignored and the push is taken.
REQ-029 Full/empty flags SHALL be registered and SHALL reflect the count after the current edge; pointers wrap modulo FIFO_DEPTH.
REQ-030 With cfg_loopback=1, RX SHALL take the internal TX serial output and tx SHALL be held 1; external rx is ignored.
REQ-031 A cfg_loopback change mid-frame SHALL take effect immediately and may corrupt the in-flight RX frame.

Reset
REQ-032 reset=1 at a clock edge SHALL, at any point including mid-frame, empty both FIFOs, put both FSMs in IDLE and clear the tick counter.
REQ-033 After reset: tx=1, tx_busy=0, tx_fifo_empty=1, tx_fifo_full=0, rx_fifo_empty=1, rx_fifo_full=0, r_data=0, r_err=0, rx_overrun=0.

Verification
REQ-034 Loopback, defaults (cfg_div=0, 8N1), push 0xA5 -> tx_busy high for 2080 clks; r_data=0xA5, r_err=00, rx_fifo_empty falls ~2000 clks after push.
REQ-035 cfg_div=3, 7 data bits, odd parity, stop2, push 0x55 -> tx sequence 0,1,0,1,0,1,0,1,1,1,1 (start, LSB-first data 1010101, parity 1, two stop bits), each bit 64 clks.
REQ-036 External rx, 8E1 frame with wrong parity bit, then a frame with stop bit 0 -> r_err=10 then 01; data bits still captured.
REQ-037 1-tick-wide low pulse on rx -> no push, rx_fifo_empty stays 1.
REQ-038 Loopback, FIFO_DEPTH=4, 5 frames with no reads -> rx_fifo_full after 4th, rx_overrun pulse on 5th, r_data = first word.
REQ-039 Assert reset mid-DATA of a TX frame with 3 words queued -> next clock tx=1, tx_fifo_empty=1, no RX push.
